board_mem_arbiter: RTL and testbench

- Shares the single-port 768-entry game-board tile memory (32x24 tiles of 20x20 px on the 640x480 screen) between two requesters: the video tile renderer (reads only) and game logic (reads and writes, e.g. pellet eaten).
- Video has absolute priority and is never stalled. Game logic uses a req/gnt handshake and is served in free cycles.
- Sits between the renderer/game FSM and the board RAM instance in DE1_SoC.

---
 rtl/board_pkg.sv | 14 +
 rtl/board_rvalid_pipe.sv | 36 +++
 rtl/board_mem_arbiter.sv | 103 ++++++++++
 tb/tb_board_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// board_pkg: board geometry, tile codes and arbiter slot encoding shared by the board memory arbiter
package board_pkg;

    localparam int TILE_W      = 2;
    localparam int BOARD_COLS  = 32;
    localparam int BOARD_ROWS  = 24;
    localparam int BOARD_DEPTH = BOARD_COLS * BOARD_ROWS;
    localparam int TILE_PX     = 20;

    typedef enum logic [TILE_W-1:0] {EMPTY, WALL, PELLET, POWER} tile_t;

    typedef enum logic [1:0] {IDLE, VID, GL_RD, GL_WR} arb_state_t;

endpackage

// File: rtl/board_rvalid_pipe.sv
// board_rvalid_pipe: delays the issued slot tag and out-of-range flag two cycles to steer RAM read data
module board_rvalid_pipe
    import board_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  arb_state_t slot,
    input  logic       oob,
    output logic       vid_rvalid,
    output logic       gl_rvalid,
    output logic       rd_oob
);

    arb_state_t s1, s2;
    logic       o1, o2;

    // two-stage tag shift; reset flushes reads still in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= IDLE;
            s2 <= IDLE;
            o1 <= 1'b0;
            o2 <= 1'b0;
        end else begin
            s1 <= slot;
            s2 <= s1;
            o1 <= oob;
            o2 <= o1;
        end
    end

    assign vid_rvalid = s2 == VID;
    assign gl_rvalid  = s2 == GL_RD;
    assign rd_oob     = o2;

endmodule

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the board tile RAM between video (priority reads) and game logic (req/gnt); BOARD_ARB_BLANK_ONLY_EN limits game-logic writes to blanking
module board_mem_arbiter
    import board_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = TILE_W,
    parameter int DEPTH  = BOARD_DEPTH,
    parameter int WAIT_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_blank,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_wdata,
    output logic              gl_gnt,
    output logic              gl_rvalid,
    output logic [DATA_W-1:0] gl_rdata,
    output logic              gl_oob,
    output logic [WAIT_W-1:0] gl_wait_max,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    arb_state_t        state, nxt;
    logic              wr_ok, gl_grant, gl_oob_c, vid_oob, oob_nxt;
    logic              vid_v, gl_v, rd_oob;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;

`ifdef BOARD_ARB_BLANK_ONLY_EN
    assign wr_ok = vid_blank;
`else
    assign wr_ok = 1'b1 | vid_blank;
`endif

    assign gl_oob_c = {1'b0, gl_addr} >= DEPTH_L;
    assign vid_oob  = {1'b0, vid_addr} >= DEPTH_L;
    assign gl_gnt   = (state == GL_RD) || (state == GL_WR);

    // slot register: the access being issued to RAM this cycle
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    // arbitration: video always wins; a request seen while its grant is showing is ignored
    always_comb begin
        nxt      = vid_req ? VID
                 : (gl_req && !gl_gnt && (!gl_we || wr_ok)) ? (gl_we ? GL_WR : GL_RD)
                 : IDLE;
        gl_grant = (nxt == GL_RD) || (nxt == GL_WR);
        oob_nxt  = vid_req ? vid_oob : gl_grant && gl_oob_c;
        wait_nxt = gl_grant ? '0
                 : (gl_req && !gl_gnt && wait_cnt != '1) ? wait_cnt + 1'b1
                 : wait_cnt;
    end

    // registered RAM command, out-of-range pulse and wait tracking
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            gl_oob      <= 1'b0;
            wait_cnt    <= '0;
            gl_wait_max <= '0;
        end else begin
            mem_addr    <= (nxt == VID) ? vid_addr : gl_grant ? gl_addr : '0;
            mem_we      <= (nxt == GL_WR) && !gl_oob_c;
            mem_wdata   <= (nxt == GL_WR) ? gl_wdata : '0;
            gl_oob      <= gl_grant && gl_oob_c;
            wait_cnt    <= wait_nxt;
            gl_wait_max <= (wait_nxt > gl_wait_max) ? wait_nxt : gl_wait_max;
        end
    end

    board_rvalid_pipe u_pipe (
        .clk        (CLOCK_50),
        .reset_n    (reset_n),
        .slot       (nxt),
        .oob        (oob_nxt),
        .vid_rvalid (vid_v),
        .gl_rvalid  (gl_v),
        .rd_oob     (rd_oob)
    );

    assign vid_rvalid = vid_v;
    assign gl_rvalid  = gl_v;
    assign vid_rdata  = (vid_v && !rd_oob) ? mem_rdata : '0;
    assign gl_rdata   = (gl_v && !rd_oob) ? mem_rdata : '0;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: directed checks of the board memory arbiter against a preloaded RAM model
module tb_board_mem_arbiter;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n = 1'b0, vid_req = 1'b0, vid_blank = 1'b0;
    logic       gl_req = 1'b0, gl_we = 1'b0;
    logic [9:0] vid_addr = '0, gl_addr = '0, mem_addr;
    logic [1:0] gl_wdata = '0, vid_rdata, gl_rdata, mem_wdata, mem_rdata;
    logic       vid_rvalid, gl_gnt, gl_rvalid, gl_oob, mem_we;
    logic [7:0] gl_wait_max;
    int         nvec = 0, nerr = 0;
    bit [1:0]   ram [1024];
    bit         wr [1024];

    board_mem_arbiter dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_blank   (vid_blank),
        .vid_rvalid  (vid_rvalid),
        .vid_rdata   (vid_rdata),
        .gl_req      (gl_req),
        .gl_we       (gl_we),
        .gl_addr     (gl_addr),
        .gl_wdata    (gl_wdata),
        .gl_gnt      (gl_gnt),
        .gl_rvalid   (gl_rvalid),
        .gl_rdata    (gl_rdata),
        .gl_oob      (gl_oob),
        .gl_wait_max (gl_wait_max),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // preload pattern; addresses past the board hold a nonzero code so zeroing is visible
    function automatic logic [1:0] pat(input int a);
        return (a >= 768) ? 2'd3 : 2'((a * 5 + (a >> 2)) % 4);
    endfunction

    // RAM model: one-cycle synchronous read, written words override the preload
    always @(posedge CLOCK_50) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= wr[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; vid_req = 1'b1; vid_addr = 10'd5;
        repeat (3) tick();
        nvec++;
        if ({vid_rvalid, vid_rdata, gl_gnt, gl_rvalid, gl_rdata, gl_oob, gl_wait_max, mem_addr, mem_we, mem_wdata} !== 29'd0) begin
            nerr++; $display("FAIL reset_zero: got %h expected 0", {vid_rvalid, vid_rdata, gl_gnt, gl_rvalid, gl_rdata, gl_oob, gl_wait_max, mem_addr, mem_we, mem_wdata});
        end
        reset_n = 1'b1;
        tick();
        nvec++;
        if ({vid_rvalid, mem_addr} !== {1'b0, 10'd5}) begin
            nerr++; $display("FAIL reset_first_issue: got %h expected %h", {vid_rvalid, mem_addr}, {1'b0, 10'd5});
        end
        tick();
        nvec++;
        if ({vid_rvalid, vid_rdata} !== {1'b1, pat(5)}) begin
            nerr++; $display("FAIL reset_first_rvalid: got %h expected %h", {vid_rvalid, vid_rdata}, {1'b1, pat(5)});
        end
        reset_n = 1'b0;
        tick();
        nvec++;
        if (vid_rvalid !== 1'b0) begin
            nerr++; $display("FAIL reset_drop_inflight: got %b expected 0", vid_rvalid);
        end
        reset_n = 1'b1; vid_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            nvec++;
            if (vid_rvalid !== 1'b0) begin
                nerr++; $display("FAIL reset_no_late_rvalid[%0d]: got %b expected 0", i, vid_rvalid);
            end
        end
    endtask

    task automatic test_video_stream();
        for (int i = 0; i <= 768; i++) begin
            vid_req  = i < 768;
            vid_addr = (i < 768) ? 10'(i) : 10'd0;
            tick();
            if (i > 0) begin
                nvec++;
                if ({vid_rvalid, vid_rdata} !== {1'b1, pat(i - 1)}) begin
                    nerr++; $display("FAIL video_stream[%0d]: got %h expected %h", i - 1, {vid_rvalid, vid_rdata}, {1'b1, pat(i - 1)});
                end
            end
        end
        tick();
        nvec++;
        if (vid_rvalid !== 1'b0) begin
            nerr++; $display("FAIL video_stream_end: got %b expected 0", vid_rvalid);
        end
        vid_req = 1'b1; vid_addr = 10'd800;
        tick();
        vid_req = 1'b0;
        tick();
        nvec++;
        if ({vid_rvalid, vid_rdata} !== 3'b100) begin
            nerr++; $display("FAIL video_oob: got %h expected 4", {vid_rvalid, vid_rdata});
        end
    endtask

    task automatic test_contention();
        vid_blank = 1'b0; vid_req = 1'b1; vid_addr = 10'd1;
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 10'd33;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++;
            if (gl_gnt !== 1'b0) begin
                nerr++; $display("FAIL contention_stall[%0d]: got %b expected 0", i, gl_gnt);
            end
        end
        vid_req = 1'b0;
        tick();
        nvec++;
        if ({gl_gnt, gl_oob, mem_we, mem_addr} !== {3'b100, 10'd33}) begin
            nerr++; $display("FAIL contention_grant: got %h expected %h", {gl_gnt, gl_oob, mem_we, mem_addr}, {3'b100, 10'd33});
        end
        gl_req = 1'b0;
        tick();
        nvec++;
        if ({gl_gnt, gl_rvalid, gl_rdata} !== {2'b01, pat(33)}) begin
            nerr++; $display("FAIL contention_rdata: got %h expected %h", {gl_gnt, gl_rvalid, gl_rdata}, {2'b01, pat(33)});
        end
        nvec++;
        if (gl_wait_max !== 8'd5) begin
            nerr++; $display("FAIL contention_wait_max: got %0d expected 5", gl_wait_max);
        end
    endtask

    task automatic test_held_request();
        vid_blank = 1'b1;
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 10'd100; gl_wdata = 2'd2;
        tick();
        nvec++;
        if ({gl_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 10'd100, 2'd2}) begin
            nerr++; $display("FAIL held_grant: got %h expected %h", {gl_gnt, mem_we, mem_addr, mem_wdata}, {2'b11, 10'd100, 2'd2});
        end
        tick();
        nvec++;
        if ({gl_gnt, mem_we, gl_rvalid} !== 3'b000) begin
            nerr++; $display("FAIL held_ignored: got %b expected 000", {gl_gnt, mem_we, gl_rvalid});
        end
        gl_req = 1'b0;
        tick();
        nvec++;
        if ({gl_gnt, mem_we, gl_rvalid} !== 3'b000) begin
            nerr++; $display("FAIL held_quiet: got %b expected 000", {gl_gnt, mem_we, gl_rvalid});
        end
        gl_req = 1'b1; gl_we = 1'b0;
        tick();
        gl_req = 1'b0;
        nvec++;
        if (gl_gnt !== 1'b1) begin
            nerr++; $display("FAIL held_readback_grant: got %b expected 1", gl_gnt);
        end
        tick();
        nvec++;
        if ({gl_rvalid, gl_rdata} !== 3'b110) begin
            nerr++; $display("FAIL held_readback: got %h expected 6", {gl_rvalid, gl_rdata});
        end
    endtask

    task automatic test_back_to_back();
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 10'd10;
        tick();
        nvec++;
        if ({gl_gnt, mem_addr} !== {1'b1, 10'd10}) begin
            nerr++; $display("FAIL b2b_first: got %h expected %h", {gl_gnt, mem_addr}, {1'b1, 10'd10});
        end
        gl_addr = 10'd11;
        tick();
        nvec++;
        if ({gl_gnt, gl_rvalid, gl_rdata} !== {2'b01, pat(10)}) begin
            nerr++; $display("FAIL b2b_gap: got %h expected %h", {gl_gnt, gl_rvalid, gl_rdata}, {2'b01, pat(10)});
        end
        tick();
        nvec++;
        if ({gl_gnt, mem_addr} !== {1'b1, 10'd11}) begin
            nerr++; $display("FAIL b2b_second: got %h expected %h", {gl_gnt, mem_addr}, {1'b1, 10'd11});
        end
        gl_req = 1'b0;
        tick();
        nvec++;
        if ({gl_rvalid, gl_rdata} !== {1'b1, pat(11)}) begin
            nerr++; $display("FAIL b2b_second_rdata: got %h expected %h", {gl_rvalid, gl_rdata}, {1'b1, pat(11)});
        end
    endtask

    task automatic test_out_of_range();
        vid_blank = 1'b1;
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 10'd800; gl_wdata = 2'd1;
        tick();
        gl_req = 1'b0;
        nvec++;
        if ({gl_gnt, gl_oob, mem_we} !== 3'b110) begin
            nerr++; $display("FAIL oob_write: got %b expected 110", {gl_gnt, gl_oob, mem_we});
        end
        tick();
        nvec++;
        if ({gl_gnt, gl_oob, mem_we, gl_rvalid} !== 4'b0000) begin
            nerr++; $display("FAIL oob_write_after: got %b expected 0000", {gl_gnt, gl_oob, mem_we, gl_rvalid});
        end
        gl_req = 1'b1; gl_we = 1'b0;
        tick();
        gl_req = 1'b0;
        nvec++;
        if ({gl_gnt, gl_oob} !== 2'b11) begin
            nerr++; $display("FAIL oob_read_grant: got %b expected 11", {gl_gnt, gl_oob});
        end
        tick();
        nvec++;
        if ({gl_rvalid, gl_rdata} !== 3'b100) begin
            nerr++; $display("FAIL oob_read_data: got %h expected 4", {gl_rvalid, gl_rdata});
        end
    endtask

    task automatic test_blank();
        vid_blank = 1'b0;
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 10'd200; gl_wdata = 2'd3;
`ifdef BOARD_ARB_BLANK_ONLY_EN
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++;
            if (gl_gnt !== 1'b0) begin
                nerr++; $display("FAIL blank_stall[%0d]: got %b expected 0", i, gl_gnt);
            end
        end
        vid_blank = 1'b1;
        tick();
        gl_req = 1'b0;
        nvec++;
        if ({gl_gnt, mem_we} !== 2'b11) begin
            nerr++; $display("FAIL blank_grant: got %b expected 11", {gl_gnt, mem_we});
        end
        tick();
        nvec++;
        if (gl_wait_max !== 8'd10) begin
            nerr++; $display("FAIL blank_wait_max: got %0d expected 10", gl_wait_max);
        end
`else
        tick();
        gl_req = 1'b0;
        nvec++;
        if ({gl_gnt, mem_we} !== 2'b11) begin
            nerr++; $display("FAIL active_write_grant: got %b expected 11", {gl_gnt, mem_we});
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_video_stream();
        test_contention();
        test_held_request();
        test_back_to_back();
        test_out_of_range();
        test_blank();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
